// File: rtl/clkdiv_ctrl.sv
// Sequencing controller for a ripple clock divider: owns its reset, mirrors its state,
// and switches the output tap only while every tap is low so the gated clock never glitches.
module clkdiv_ctrl #(
   parameter  int STAGES      = 4,
   parameter  int RST_CYCLES  = 8,
   parameter  int DEFAULT_SEL = 0,
   localparam int SELW        = $clog2(STAGES + 1)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   output logic              o_div_rstb,
   input  logic              i_ratio_valid,
   output logic              o_ratio_ready,
   input  logic [SELW-1:0]   i_ratio,
   output logic [SELW-1:0]   o_sel,
   output logic              o_clk_en,
   output logic              o_locked,
   output logic [STAGES-1:0] o_phase,
   output logic              o_cfg_err
);

   localparam int CNTW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_HOLD,
      S_ALIGN_ON,
      S_RUN,
      S_ALIGN_OFF,
      S_SWITCH
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [CNTW-1:0]   r_cnt, w_cnt_nxt;
   logic              r_div_rstb, w_div_rstb_nxt;
   logic              r_clk_en, w_clk_en_nxt;
   logic [SELW-1:0]   r_sel, w_sel_nxt;
   logic [SELW-1:0]   r_ratio_lat, w_ratio_lat_nxt;
   logic              r_cfg_err, w_cfg_err_nxt;
   logic [STAGES-1:0] r_phase;
   logic              w_phase_zero;

   assign w_phase_zero = (r_phase == '0);

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = '0;
      w_div_rstb_nxt  = r_div_rstb;
      w_clk_en_nxt    = r_clk_en;
      w_sel_nxt       = r_sel;
      w_ratio_lat_nxt = r_ratio_lat;
      w_cfg_err_nxt   = 1'b0;

      if (!i_en) begin
         w_state_nxt    = S_HOLD;
         w_div_rstb_nxt = 1'b0;
         w_clk_en_nxt   = 1'b0;
      end else begin
         case (r_state)
            S_HOLD: begin
               w_div_rstb_nxt = 1'b0;
               w_clk_en_nxt   = 1'b0;
               if (r_cnt == CNTW'(RST_CYCLES - 1)) begin
                  w_state_nxt    = S_ALIGN_ON;
                  w_div_rstb_nxt = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + CNTW'(1);
               end
            end
            S_ALIGN_ON: begin
               if (w_phase_zero && r_div_rstb) begin
                  w_clk_en_nxt = 1'b1;
                  w_state_nxt  = S_RUN;
               end
            end
            S_RUN: begin
               if (i_ratio_valid) begin
                  if (i_ratio <= SELW'(STAGES)) begin
                     w_ratio_lat_nxt = i_ratio;
                     w_state_nxt     = S_ALIGN_OFF;
                  end else begin
                     w_cfg_err_nxt = 1'b1;
                  end
               end
            end
            S_ALIGN_OFF: begin
               if (w_phase_zero) begin
                  w_clk_en_nxt = 1'b0;
                  w_state_nxt  = S_SWITCH;
               end
            end
            S_SWITCH: begin
               w_sel_nxt   = r_ratio_lat;
               w_state_nxt = S_ALIGN_ON;
            end
            default: begin
               w_state_nxt    = S_HOLD;
               w_div_rstb_nxt = 1'b0;
               w_clk_en_nxt   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_HOLD;
         r_cnt       <= '0;
         r_div_rstb  <= 1'b0;
         r_clk_en    <= 1'b0;
         r_sel       <= SELW'(DEFAULT_SEL);
         r_ratio_lat <= SELW'(DEFAULT_SEL);
         r_cfg_err   <= 1'b0;
         r_phase     <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_div_rstb  <= w_div_rstb_nxt;
         r_clk_en    <= w_clk_en_nxt;
         r_sel       <= w_sel_nxt;
         r_ratio_lat <= w_ratio_lat_nxt;
         r_cfg_err   <= w_cfg_err_nxt;
         // Divider flops clear as soon as their reset asserts, so the mirror zeroes with it.
         r_phase     <= (r_div_rstb && w_div_rstb_nxt) ? r_phase - STAGES'(1) : '0;
      end
   end

   assign o_div_rstb    = r_div_rstb;
   assign o_clk_en      = r_clk_en;
   assign o_sel         = r_sel;
   assign o_phase       = r_phase;
   assign o_cfg_err     = r_cfg_err;
   assign o_locked      = (r_state == S_RUN);
   assign o_ratio_ready = (r_state == S_RUN) && i_en;

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Directed bench for clkdiv_ctrl with STAGES=4, RST_CYCLES=8, DEFAULT_SEL=0.
module tb_clkdiv_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       div_rstb;
   logic       ratio_valid;
   logic       ratio_ready;
   logic [2:0] ratio;
   logic [2:0] sel;
   logic       clk_en;
   logic       locked;
   logic [3:0] phase;
   logic       cfg_err;

   int n_chk  = 0;
   int n_fail = 0;

   clkdiv_ctrl #(.STAGES(4), .RST_CYCLES(8), .DEFAULT_SEL(0)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_en          (en),
      .o_div_rstb    (div_rstb),
      .i_ratio_valid (ratio_valid),
      .o_ratio_ready (ratio_ready),
      .i_ratio       (ratio),
      .o_sel         (sel),
      .o_clk_en      (clk_en),
      .o_locked      (locked),
      .o_phase       (phase),
      .o_cfg_err     (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock; any sel change outside reset must happen with clk_en low on both sides.
   task automatic tick();
      logic [2:0] prev_sel;
      logic       prev_en;
      logic       prev_rst;
      prev_sel = sel;
      prev_en  = clk_en;
      prev_rst = rst;
      @(posedge clk);
      #1;
      if (sel !== prev_sel && !prev_rst)
         chk("sel_change_gated", {30'd0, prev_en, clk_en}, 32'd0);
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; ratio_valid = 1'b0; ratio = 3'd0;
      tick_n(2);
      chk("rst_div_rstb", div_rstb, 0);
      chk("rst_sel", sel, 0);
      chk("rst_clk_en", clk_en, 0);
      chk("rst_locked", locked, 0);
      chk("rst_ready", ratio_ready, 0);
      chk("rst_phase", phase, 0);
      chk("rst_cfg_err", cfg_err, 0);

      // Power-up
      rst = 1'b0; en = 1'b1;
      tick_n(7);
      chk("pu_hold_7", div_rstb, 0);
      tick();
      chk("pu_release", div_rstb, 1);
      chk("pu_release_clk_en", clk_en, 0);
      chk("pu_release_phase", phase, 0);
      chk("pu_release_locked", locked, 0);
      tick();
      chk("pu_clk_en", clk_en, 1);
      chk("pu_locked", locked, 1);
      chk("pu_ready", ratio_ready, 1);
      chk("pu_phase15", phase, 15);
      chk("pu_sel", sel, 0);
      tick();
      chk("pu_phase14", phase, 14);

      // Ratio change to 2
      ratio_valid = 1'b1; ratio = 3'd2;
      tick();
      ratio_valid = 1'b0;
      chk("chg_ready_low", ratio_ready, 0);
      chk("chg_locked_low", locked, 0);
      chk("chg_clk_en_still", clk_en, 1);
      chk("chg_phase13", phase, 13);
      tick_n(13);
      chk("chg_phase0", phase, 0);
      chk("chg_clk_en_before_off", clk_en, 1);
      tick();
      chk("chg_clk_en_off", clk_en, 0);
      chk("chg_sel_old", sel, 0);
      tick();
      chk("chg_sel_new", sel, 2);
      tick_n(14);
      chk("chg_align_on_wait", clk_en, 0);
      chk("chg_align_on_phase", phase, 0);
      tick();
      chk("chg_clk_en_on", clk_en, 1);
      chk("chg_relocked", locked, 1);
      chk("chg_phase15", phase, 15);

      // Out-of-range ratio
      ratio_valid = 1'b1; ratio = 3'd5;
      tick();
      ratio_valid = 1'b0;
      chk("bad_cfg_err", cfg_err, 1);
      chk("bad_sel", sel, 2);
      chk("bad_clk_en", clk_en, 1);
      chk("bad_locked", locked, 1);
      tick();
      chk("bad_cfg_err_pulse", cfg_err, 0);
      chk("bad_locked_after", locked, 1);

      // Request held while busy
      ratio_valid = 1'b1; ratio = 3'd1;
      tick();
      ratio = 3'd3;
      chk("busy_ready0", ratio_ready, 0);
      chk("busy_phase12", phase, 12);
      tick_n(12);
      chk("busy_ready_off", ratio_ready, 0);
      chk("busy_phase0", phase, 0);
      tick();
      chk("busy_clk_en_off", clk_en, 0);
      tick();
      chk("busy_sel1", sel, 1);
      tick_n(14);
      chk("busy_ready_on_wait", ratio_ready, 0);
      tick();
      chk("busy_ready_run", ratio_ready, 1);
      chk("busy_clk_en_run", clk_en, 1);
      tick();
      ratio_valid = 1'b0;
      chk("busy_accepted", locked, 0);
      chk("busy_sel_kept", sel, 1);
      chk("busy_phase14", phase, 14);
      tick_n(14);
      chk("busy2_phase0", phase, 0);
      tick();
      chk("busy2_clk_en_off", clk_en, 0);
      tick();
      chk("busy2_sel3", sel, 3);
      tick_n(15);
      chk("busy2_clk_en_on", clk_en, 1);
      chk("busy2_locked", locked, 1);
      chk("busy2_phase15", phase, 15);

      // en drop during ALIGN_OFF
      ratio_valid = 1'b1; ratio = 3'd2;
      tick();
      ratio_valid = 1'b0;
      chk("endrop_accepted", locked, 0);
      chk("endrop_phase14", phase, 14);
      tick();
      en = 1'b0;
      tick();
      chk("endrop_div_rstb", div_rstb, 0);
      chk("endrop_clk_en", clk_en, 0);
      chk("endrop_phase", phase, 0);
      chk("endrop_sel", sel, 3);
      chk("endrop_locked", locked, 0);
      en = 1'b1;
      tick_n(7);
      chk("endrop_hold_7", div_rstb, 0);
      tick();
      chk("endrop_release", div_rstb, 1);
      tick();
      chk("endrop_relock_clk_en", clk_en, 1);
      chk("endrop_relock_locked", locked, 1);
      chk("endrop_relock_sel", sel, 3);

      // en low together with a request: en wins
      en = 1'b0; ratio_valid = 1'b1; ratio = 3'd1;
      #1;
      chk("en_wins_ready", ratio_ready, 0);
      tick();
      chk("en_wins_locked", locked, 0);
      chk("en_wins_div_rstb", div_rstb, 0);
      en = 1'b1; ratio_valid = 1'b0;
      tick_n(8);
      chk("en_wins_release", div_rstb, 1);
      tick();
      chk("en_wins_relock", locked, 1);
      chk("en_wins_sel", sel, 3);

      // Synchronous reset mid-RUN
      tick();
      rst = 1'b1;
      tick();
      chk("mrst_div_rstb", div_rstb, 0);
      chk("mrst_sel", sel, 0);
      chk("mrst_locked", locked, 0);
      chk("mrst_clk_en", clk_en, 0);
      chk("mrst_phase", phase, 0);
      chk("mrst_ready", ratio_ready, 0);
      rst = 1'b0;
      tick_n(7);
      chk("mrst_hold_7", div_rstb, 0);
      tick();
      chk("mrst_release", div_rstb, 1);
      tick();
      chk("mrst_clk_en", clk_en, 1);
      chk("mrst_locked_again", locked, 1);
      chk("mrst_sel_default", sel, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
